// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding, parity modes and the baud-increment helper
// used by both the transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Rounded (BAUD / CLK_FREQ) * 2^acc_width, prescaled by 16 so the product fits 32 bits.
    function automatic int uart_baud_inc(input int clk_freq, input int baud, input int acc_width);
        longint num;
        longint den;
        num = (longint'(baud) << (acc_width - 4)) + (longint'(clk_freq) >> 5);
        den = longint'(clk_freq) >> 4;
        return int'(num / den);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional baud-rate tick generator: one-cycle tick on each accumulator carry.
// Latency: first tick 2^ACC_WIDTH/INC cycles after clear; no backpressure (free-running).
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int ACC_WIDTH = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int                 INC_I = uart_baud_inc(CLK_FREQ, BAUD, ACC_WIDTH);
    localparam logic [ACC_WIDTH:0] INC   = (ACC_WIDTH + 1)'(INC_I);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH:0]   w_sum;

    // The carry of the next sum is the tick, so a cleared accumulator gives a full first period.
    assign w_sum  = {1'b0, r_acc} + INC;
    assign o_tick = w_sum[ACC_WIDTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable RS-232 transmitter (DATA_BITS, parity, stop bits), LSB first.
// Start bit on txd the cycle after accept; tx_ready low (tx_valid ignored) until the frame ends.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int ACC_WIDTH = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [8:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_txd
);

    localparam int         BAUD_INC  = uart_baud_inc(CLK_FREQ, BAUD, ACC_WIDTH);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    if (BAUD_INC == 0) begin : g_chk_inc
        $error("uart_tx_cfg: BAUD_INC is zero for this CLK_FREQ/BAUD/ACC_WIDTH");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    uart_state_t          r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [3:0]           r_cnt, w_cnt_nxt;
    logic                 r_par, w_par_nxt;
    logic                 r_txd, w_txd_nxt;
    logic                 r_done, w_done_nxt;
    logic                 w_tick;
    logic                 w_accept;
    logic [DATA_BITS-1:0] w_data;
    logic                 w_par_calc;
    logic                 w_unused;

    assign w_data     = i_tx_data[DATA_BITS-1:0];
    assign w_par_calc = (PARITY == PAR_ODD) ? ~^w_data : ^w_data;
    assign w_accept   = (r_state == ST_IDLE) && i_tx_valid;
    assign w_unused   = &{1'b0, i_tx_data};

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_baud (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clear(w_accept),
        .o_tick (w_tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_par   <= w_par_nxt;
            r_txd   <= w_txd_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_par_nxt   = r_par;
        w_done_nxt  = 1'b0;
        w_txd_nxt   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (i_tx_valid) begin
                    w_state_nxt = ST_START;
                    w_shift_nxt = w_data;
                    w_par_nxt   = w_par_calc;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    w_cnt_nxt   = r_cnt + 4'd1;
                    if (r_cnt == LAST_DATA) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = ST_STOP;
                    w_cnt_nxt   = '0;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_cnt == LAST_STOP) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // txd is registered from the next state so the line moves in step with the FSM.
        case (w_state_nxt)
            ST_START:  w_txd_nxt = 1'b0;
            ST_DATA:   w_txd_nxt = w_shift_nxt[0];
            ST_PARITY: w_txd_nxt = w_par_nxt;
            default:   w_txd_nxt = 1'b1;
        endcase
    end

    assign o_tx_ready = (r_state == ST_IDLE);
    assign o_tx_busy  = (r_state != ST_IDLE);
    assign o_tx_done  = r_done;
    assign o_txd      = r_txd;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations (8N1, 8E1, 8O1, 7N2) at 16 clocks per bit,
// compared cycle by cycle against a frame model built from the serial framing rules.
module tb_uart_tx_cfg;

    logic       clk;
    logic       rst_n;
    logic [3:0] tx_valid;
    logic [8:0] tx_data [4];
    wire  [3:0] tx_ready;
    wire  [3:0] tx_busy;
    wire  [3:0] tx_done;
    wire  [3:0] txd;

    int cfg_db  [4] = '{8, 8, 8, 7};
    int cfg_par [4] = '{0, 2, 1, 0};
    int cfg_sb  [4] = '{1, 1, 1, 2};

    int n_assert = 0;
    int n_fail   = 0;

    logic exp_q    [$];
    logic obs_txd  [$];
    logic obs_busy [$];
    logic obs_done [$];
    logic obs_rdy  [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .ACC_WIDTH(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data[0]), .i_tx_valid(tx_valid[0]),
        .o_tx_ready(tx_ready[0]), .o_tx_busy(tx_busy[0]), .o_tx_done(tx_done[0]), .o_txd(txd[0]));

    uart_tx_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .ACC_WIDTH(16),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data[1]), .i_tx_valid(tx_valid[1]),
        .o_tx_ready(tx_ready[1]), .o_tx_busy(tx_busy[1]), .o_tx_done(tx_done[1]), .o_txd(txd[1]));

    uart_tx_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .ACC_WIDTH(16),
                  .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data[2]), .i_tx_valid(tx_valid[2]),
        .o_tx_ready(tx_ready[2]), .o_tx_busy(tx_busy[2]), .o_tx_done(tx_done[2]), .o_txd(txd[2]));

    uart_tx_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .ACC_WIDTH(16),
                  .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data[3]), .i_tx_valid(tx_valid[3]),
        .o_tx_ready(tx_ready[3]), .o_tx_busy(tx_busy[3]), .o_tx_done(tx_done[3]), .o_txd(txd[3]));

    // Expected line level per clock for one frame: start, data LSB first, parity, stop bits.
    task automatic model_frame(input int k, input logic [8:0] d);
        int   ones;
        logic b;
        ones = 0;
        repeat (16) exp_q.push_back(1'b0);
        for (int i = 0; i < cfg_db[k]; i++) begin
            b = d[i];
            ones += int'(b);
            repeat (16) exp_q.push_back(b);
        end
        if (cfg_par[k] != 0) begin
            b = (cfg_par[k] == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            repeat (16) exp_q.push_back(b);
        end
        repeat (16 * cfg_sb[k]) exp_q.push_back(1'b1);
    endtask

    // Offer d on instance k, then record n cycles after the accepting edge.
    task automatic send_capture(input int k, input logic [8:0] d, input int n,
                                input int drop_at, input logic [8:0] d2);
        int waited;
        obs_txd.delete(); obs_busy.delete(); obs_done.delete(); obs_rdy.delete();
        waited = 0;
        while (tx_ready[k] !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        n_assert++;
        if (tx_ready[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_wait cfg%0d: tx_ready=%b after %0d cycles, required 1", k, tx_ready[k], waited);
        end
        tx_data[k]  = d;
        tx_valid[k] = 1'b1;
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs_txd.push_back(txd[k]);
            obs_busy.push_back(tx_busy[k]);
            obs_done.push_back(tx_done[k]);
            obs_rdy.push_back(tx_ready[k]);
            if (i == 0) tx_data[k] = d2;
            if (i == drop_at) tx_valid[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        tx_valid = 4'b0000;
        for (int k = 0; k < 4; k++) tx_data[k] = '0;
        repeat (3) @(negedge clk);
        n_assert++;
        if (txd !== 4'hF) begin n_fail++; $display("FAIL reset_txd: got %b, required 1111", txd); end
        n_assert++;
        if (tx_ready !== 4'hF) begin n_fail++; $display("FAIL reset_ready: got %b, required 1111", tx_ready); end
        n_assert++;
        if (tx_busy !== 4'h0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0000", tx_busy); end
        n_assert++;
        if (tx_done !== 4'h0) begin n_fail++; $display("FAIL reset_done: got %b, required 0000", tx_done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] d;
        int         bad;
        d = 9'($urandom) & 9'h0FB;
        exp_q.delete();
        model_frame(0, d);
        send_capture(0, d, 54, 0, 9'h1FF);
        bad = 0;
        for (int i = 48; i < 54; i++) if (obs_txd[i] !== exp_q[i]) bad++;
        n_assert++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abort_pre_bit2 data=%h: %0d of 6 cycles wrong, required txd=0", d, bad);
        end
        #2 rst_n = 1'b0;
        #1;
        n_assert++;
        if ({txd[0], tx_ready[0], tx_busy[0], tx_done[0]} !== 4'b1100) begin
            n_fail++;
            $display("FAIL abort_async txd/ready/busy/done: got %b%b%b%b, required 1100",
                     txd[0], tx_ready[0], tx_busy[0], tx_done[0]);
        end
        repeat (2) @(negedge clk);
        n_assert++;
        if ({txd[0], tx_ready[0], tx_busy[0], tx_done[0]} !== 4'b1100) begin
            n_fail++;
            $display("FAIL abort_held txd/ready/busy/done: got %b%b%b%b, required 1100",
                     txd[0], tx_ready[0], tx_busy[0], tx_done[0]);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_frames();
        int         ks [5] = '{0, 0, 1, 2, 3};
        logic [8:0] ds [5] = '{9'h000, 9'h055, 9'h0A5, 9'h0A5, 9'h0FF};
        int         k;
        int         len;
        int         bad;
        logic [8:0] d;
        for (int t = 0; t < 17; t++) begin
            if (t < 5) begin
                k = ks[t];
                d = ds[t];
            end else begin
                k = $urandom_range(0, 3);
                d = 9'($urandom);
                repeat ($urandom_range(0, 30)) @(negedge clk);
            end
            exp_q.delete();
            model_frame(k, d);
            len = exp_q.size();
            send_capture(k, d, len + 2, 0, 9'($urandom));
            for (int j = 0; j < len / 16; j++) begin
                bad = 0;
                for (int c = 0; c < 16; c++) begin
                    if (obs_txd[j*16+c] !== exp_q[j*16+c] || obs_busy[j*16+c] !== 1'b1 ||
                        obs_done[j*16+c] !== 1'b0) bad++;
                end
                n_assert++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL frame cfg%0d data=%h bit%0d: %0d of 16 cycles wrong, txd=%b required %b (busy=1 done=0)",
                             k, d, j, bad, obs_txd[j*16], exp_q[j*16]);
                end
            end
            n_assert++;
            if ({obs_done[len], obs_rdy[len], obs_txd[len]} !== 3'b111) begin
                n_fail++;
                $display("FAIL frame_end cfg%0d data=%h: done/ready/txd=%b%b%b at cycle %0d, required 111",
                         k, d, obs_done[len], obs_rdy[len], obs_txd[len], len + 1);
            end
            n_assert++;
            if (obs_done[len+1] !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse cfg%0d: tx_done=%b one cycle after pulse, required 0", k, obs_done[len+1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   len;
        int   bad;
        int   ndone;
        int   idx;
        logic e_txd, e_busy, e_done;
        exp_q.delete();
        model_frame(0, 9'h012);
        len = exp_q.size();
        exp_q.push_back(1'b1);
        model_frame(0, 9'h034);
        exp_q.push_back(1'b1);
        send_capture(0, 9'h012, 2*len + 32, len + 40, 9'h034);
        ndone = 0;
        for (int j = 0; j < (2*len + 32) / 16; j++) begin
            bad = 0;
            for (int c = 0; c < 16; c++) begin
                idx    = j*16 + c;
                e_done = (idx == len) || (idx == 2*len + 1);
                e_busy = !(e_done || idx > 2*len + 1);
                e_txd  = (idx < exp_q.size()) ? exp_q[idx] : 1'b1;
                if (obs_txd[idx] !== e_txd || obs_busy[idx] !== e_busy || obs_done[idx] !== e_done) bad++;
                if (obs_done[idx] === 1'b1) ndone++;
            end
            n_assert++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL b2b chunk%0d: %0d of 16 cycles wrong, txd=%b required %b",
                         j, bad, obs_txd[j*16], (j*16 < exp_q.size()) ? exp_q[j*16] : 1'b1);
            end
        end
        n_assert++;
        if (ndone != 2) begin
            n_fail++;
            $display("FAIL b2b_frame_count: %0d done pulses, required 2", ndone);
        end
        n_assert++;
        if (obs_txd[len] !== 1'b1 || obs_txd[len+1] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: txd=%b,%b around done, required 1,0", obs_txd[len], obs_txd[len+1]);
        end
    endtask

    task automatic test_phase();
        int zeros;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        send_capture(0, 9'h001, 40, 0, 9'h000);
        zeros = 0;
        for (int i = 0; i < 40; i++) if (obs_txd[i] === 1'b0 && i == zeros) zeros++;
        n_assert++;
        if (zeros != 16) begin
            n_fail++;
            $display("FAIL start_phase: start bit lasted %0d cycles, required 16", zeros);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_frames();
        test_back_to_back();
        test_phase();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised RS-232 asynchronous transmitter and successor to the fixed 8N2 transmitter. Sends one frame per accepted byte over a valid/ready handshake, LSB first. Data width, parity mode and stop-bit count are configurable. The baud generator is re-phased at frame start, so the start bit always lasts a full bit period. Sits between a byte source (FIFO or command engine) and the board TxD pin.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
ACC_WIDTH, 16, baud accumulator width (carry bit is extra)
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
BAUD_INC, ((BAUD<<(ACC_WIDTH-4))+(CLK_FREQ>>5))/(CLK_FREQ>>4), accumulator increment (derived; do not override)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
tx_data  in  9  frame payload; bits [DATA_BITS-1:0] used, upper bits ignored
tx_valid  in  1  source has a byte to send
tx_ready  out  1  high when the block can accept; transfer occurs when tx_valid & tx_ready at a clock edge
tx_busy  out  1  frame in progress (the inverse of tx_ready)
tx_done  out  1  one-cycle pulse after the last stop bit completes
txd  out  1  serial line, idle high, registered output

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - txd=1, tx_ready=1, tx_busy=0, tx_done=0.
  - State=IDLE, accumulator=0, bit counter=0, shift register=0.
  - Asserting rst_n mid-frame aborts the frame immediately; txd returns high with no glitch to 0.
- Baud tick (sub-module):
  - acc <= acc[ACC_WIDTH-1:0] + BAUD_INC every cycle; tick = acc[ACC_WIDTH].
  - The accept cycle clears acc to 0, so the first tick arrives 2^ACC_WIDTH/BAUD_INC cycles later (rounded up).
- Accept: in the cycle where tx_valid & tx_ready:
  - latch tx_data[DATA_BITS-1:0] into the shift register;
  - compute the parity bit;
  - state -> START; txd=0 from the next cycle; tx_ready=0 from the next cycle.
- States and transitions (each advance happens on a tick):
  - IDLE: txd=1, waits for accept.
  - START: txd=0; on tick -> DATA, bit counter=0.
  - DATA: txd=shift[0]; on tick, shift right and increment the counter. At counter=DATA_BITS-1, go to PARITY if PARITY!=0, otherwise STOP.
  - PARITY: txd=parity bit; on tick -> STOP.
  - STOP: txd=1 for STOP_BITS ticks; on the final tick -> IDLE.
- Parity:
  - odd: the bit makes the total ones count (data + parity) odd.
  - even: the bit makes the total ones count even.
- Frame completion:
  - tx_done pulses the cycle the block enters IDLE; tx_ready=1 in that same cycle.
  - Back-to-back: tx_valid held high is accepted in the tx_done cycle, so there is no idle gap beyond the stop bits.
- Handshake edge cases:
  - tx_valid while busy is ignored.
  - tx_data may change freely after accept.
- Frame length: 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bit periods.
- Elaboration checks: error if BAUD_INC==0, if DATA_BITS is outside 5..9, if PARITY>2, or if STOP_BITS is not 1 or 2.

Decomposition:
- Shared package uart_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP;
  - parity constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - baud-increment function used by both TX and a future RX.
- One sub-module: uart_baud_tick (params CLK_FREQ, BAUD, ACC_WIDTH; ports clk, rst_n, clear, tick).

Test Plan:
Use CLK_FREQ=1600000, BAUD=100000, giving BAUD_INC=4096 and exactly 16 clocks per bit.
1. 8N1, send 0x55 -> txd low 16 clks, then 1,0,1,0,1,0,1,0 at 16 clks each, then high 16 clks. tx_done is the 161st cycle after accept; tx_busy is high 160 cycles.
2. 8E1 and 8O1, send 0xA5 -> even parity bit=0, odd parity bit=1; frame is 176 clks.
3. DATA_BITS=7, STOP_BITS=2, send 0xFF -> only 7 data ones, then a 32-clk stop. Bit 7 is ignored; frame is 160 clks.
4. tx_valid held high with 0x12 then 0x34 -> second start bit begins the cycle after tx_done. tx_valid while busy is not accepted; exactly 2 frames are sent.
5. rst_n pulsed low in the 3rd data bit -> txd=1 asynchronously and tx_ready=1. A subsequent 0x00 frame is correct.
6. Accept 40 cycles after reset with a free-running tick -> start bit is still exactly 16 clocks (phase cleared).
